// File: rtl/fp_addsub_pipe.sv
// Purpose : pipelined IEEE-754-style add/subtract (align, add, normalise, round/pack); `FPADD_ROUND_EN selects RNE rounding, truncation otherwise.
// Latency : 3 cycles from input accept to out_valid, one result per cycle with out_ready high.
// Backpr. : global stall, in_ready = ~out_valid | out_ready; every stage holds while stalled.
module fp_addsub_pipe #(
  parameter int EXP_WIDTH  = 5,
  parameter int MANT_WIDTH = 10,
  parameter int BIT_WIDTH  = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a_operand,
  input  logic [BIT_WIDTH-1:0] b_operand,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 exception
);

  // aligned significand: hidden + mantissa + guard/round/sticky
  localparam int SW     = MANT_WIDTH + 4;
  localparam int SHW    = $clog2(SW + 1);
  localparam int XW     = EXP_WIDTH + 2;
  localparam int MAX_SH = MANT_WIDTH + 3;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
`ifdef FPADD_ROUND_EN
  localparam int RW = MANT_WIDTH + 3;   // mantissa plus guard/round/sticky kept for rounding
`else
  localparam int RW = MANT_WIDTH;       // low bits are simply dropped
`endif

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- stage 1: align ----------------
  logic                  a_sign, b_sign, l_sign, s_sign, in_exc, swap;
  logic [EXP_WIDTH-1:0]  a_exp, b_exp, l_exp, s_exp, exp_diff;
  logic [MANT_WIDTH-1:0] a_man, b_man, l_man, s_man;
  logic [SHW-1:0]        sh;
  logic [SW-1:0]         l_sig, s_sig, s_aligned;
  logic [2*SW-1:0]       s_wide;

  // unpack, flush zero/subnormal, order by magnitude, shift the smaller operand with sticky
  always_comb begin
    a_sign = a_operand[BIT_WIDTH-1];
    a_exp  = a_operand[BIT_WIDTH-2 -: EXP_WIDTH];
    a_man  = a_operand[MANT_WIDTH-1:0];
    b_sign = b_operand[BIT_WIDTH-1] ^ sub;
    b_exp  = b_operand[BIT_WIDTH-2 -: EXP_WIDTH];
    b_man  = b_operand[MANT_WIDTH-1:0];
    in_exc = (a_exp == EXP_MAX) | (b_exp == EXP_MAX);
    if (a_exp == '0) begin
      a_sign = 1'b0;
      a_man  = '0;
    end
    if (b_exp == '0) begin
      b_sign = 1'b0;
      b_man  = '0;
    end
    swap   = {b_exp, b_man} > {a_exp, a_man};
    l_sign = swap ? b_sign : a_sign;
    l_exp  = swap ? b_exp  : a_exp;
    l_man  = swap ? b_man  : a_man;
    s_sign = swap ? a_sign : b_sign;
    s_exp  = swap ? a_exp  : b_exp;
    s_man  = swap ? a_man  : b_man;
    exp_diff = l_exp - s_exp;
    if (int'(exp_diff) > MAX_SH) sh = SHW'(MAX_SH);
    else                         sh = SHW'(exp_diff);
    l_sig     = {|l_exp, l_man, 3'b000};
    s_sig     = {|s_exp, s_man, 3'b000};
    s_wide    = {s_sig, {SW{1'b0}}} >> sh;
    s_aligned = s_wide[2*SW-1:SW];
    s_aligned[0] = s_aligned[0] | (|s_wide[SW-1:0]);
  end

  logic                 v1, x1, sgn_l1, sgn_s1;
  logic [EXP_WIDTH-1:0] exp1;
  logic [SW-1:0]        sig_l1, sig_s1;

  // stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; x1 <= 1'b0; sgn_l1 <= 1'b0; sgn_s1 <= 1'b0;
      exp1 <= '0; sig_l1 <= '0; sig_s1 <= '0;
    end else if (advance) begin
      v1 <= in_valid; x1 <= in_exc; sgn_l1 <= l_sign; sgn_s1 <= s_sign;
      exp1 <= l_exp; sig_l1 <= l_sig; sig_s1 <= s_aligned;
    end
  end

  // ---------------- stage 2: add ----------------
  logic [SW:0] sum_c;

  // larger magnitude is always the minuend, so the difference is never negative
  always_comb begin
    if (sgn_l1 ^ sgn_s1) sum_c = {1'b0, sig_l1} - {1'b0, sig_s1};
    else                 sum_c = {1'b0, sig_l1} + {1'b0, sig_s1};
  end

  logic                 v2, x2, sgn2;
  logic [EXP_WIDTH-1:0] exp2;
  logic [SW:0]          sum2;

  // stage 2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0; x2 <= 1'b0; sgn2 <= 1'b0; exp2 <= '0; sum2 <= '0;
    end else if (advance) begin
      v2 <= v1; x2 <= x1; sgn2 <= sgn_l1; exp2 <= exp1; sum2 <= sum_c;
    end
  end

  // ---------------- stage 3: normalise ----------------
  logic [SHW-1:0] lzc;
  logic [SW-1:0]  n_sig;
  logic [XW-1:0]  n_exp;

  // carry-out shifts right with sticky; otherwise leading-zero count drives a left shift
  always_comb begin
    lzc = SHW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum2[i]) lzc = SHW'(SW - 1 - i);
    end
    if (sum2[SW]) begin
      n_sig = {sum2[SW:2], sum2[1] | sum2[0]};
      n_exp = {2'b00, exp2} + XW'(1);
    end else begin
      n_sig = sum2[SW-1:0] << lzc;
      n_exp = {2'b00, exp2} - XW'(lzc);
    end
  end

  logic                 v3, x3, z3, sgn3;
  logic [XW-1:0]        exp3;
  logic [RW-1:0]        sig3;

  // stage 3 register; a clear hidden bit after normalising means an exact zero
  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0; x3 <= 1'b0; z3 <= 1'b0; sgn3 <= 1'b0; exp3 <= '0; sig3 <= '0;
    end else if (advance) begin
      v3 <= v2; x3 <= x2; z3 <= ~n_sig[SW-1]; sgn3 <= sgn2; exp3 <= n_exp;
      sig3 <= n_sig[SW-2 -: RW];
    end
  end

  // ---------------- round and pack ----------------
  logic                  round_up, ovf, unf;
  logic [MANT_WIDTH:0]   mant_w;
  logic [XW-1:0]         exp_f;
  logic [BIT_WIDTH-1:0]  res_c;
  logic                  exc_c;

  // rounding carry bumps the exponent before the overflow test
  always_comb begin
`ifdef FPADD_ROUND_EN
    round_up = sig3[2] & (sig3[1] | sig3[0] | sig3[3]);
    mant_w   = {1'b0, sig3[RW-1:3]} + {{MANT_WIDTH{1'b0}}, round_up};
`else
    round_up = 1'b0;
    mant_w   = {1'b0, sig3};
`endif
    exp_f = exp3 + {{(XW-1){1'b0}}, mant_w[MANT_WIDTH]};
    unf   = exp3[XW-1] | (exp3 == '0);
    ovf   = ~exp_f[XW-1] & (exp_f[XW-2:0] >= {1'b0, EXP_MAX});
    exc_c = 1'b0;
    if (x3) begin
      res_c = '0;
      exc_c = 1'b1;
    end else if (z3) begin
      res_c = '0;
    end else if (unf) begin
      res_c = {sgn3, {(BIT_WIDTH-1){1'b0}}};
    end else if (ovf) begin
      res_c = {sgn3, EXP_MAX, {MANT_WIDTH{1'b0}}};
      exc_c = 1'b1;
    end else begin
      res_c = {sgn3, exp_f[EXP_WIDTH-1:0], mant_w[MANT_WIDTH-1:0]};
    end
  end

  // output register; data loads only with a real result so it stays stable across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; result <= '0; exception <= 1'b0;
    end else if (advance) begin
      out_valid <= v3;
      if (v3) begin
        result    <= res_c;
        exception <= exc_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe at default widths (half precision).
// Each scenario task drives its own vectors and compares inline.
// Expected rounding vector depends on `FPADD_ROUND_EN.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, exception;
  logic [15:0] a_operand, b_operand, result;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .exception(exception)
  );

  // issue one operation with out_ready high and wait (bounded) for its result
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [15:0] res, output logic exc, output int lat);
    bit got = 0;
    @(posedge clk); #1;
    a_operand = a; b_operand = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    res = '0; exc = 1'b0; lat = -1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1; lat = k; res = result; exc = exception;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    a_operand = '0; b_operand = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result: got %h want 0000", result); end
    n_cmp++; if (exception !== 1'b0) begin n_err++; $display("FAIL reset_exception: got %b want 0", exception); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    logic [15:0] r; logic e; int lat;
    run_op(16'h3C00, 16'h4000, 1'b0, r, e, lat);
    n_cmp++; if (r !== 16'h4200) begin n_err++; $display("FAIL add_1p2: got %h want 4200", r); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL add_1p2_exc: got %b want 0", e); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL add_latency: got %0d want 3", lat); end
    run_op(16'h3800, 16'hBE00, 1'b0, r, e, lat);
    n_cmp++; if (r !== 16'hBC00) begin n_err++; $display("FAIL add_mixed_sign: got %h want bc00", r); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL add_mixed_sign_exc: got %b want 0", e); end
  endtask

  task automatic test_sub();
    logic [15:0] r; logic e; int lat;
    run_op(16'h4200, 16'h3C00, 1'b1, r, e, lat);
    n_cmp++; if (r !== 16'h4000) begin n_err++; $display("FAIL sub_3m1: got %h want 4000", r); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL sub_latency: got %0d want 3", lat); end
    run_op(16'h3C00, 16'h3C00, 1'b1, r, e, lat);
    n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL sub_zero: got %h want 0000", r); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL sub_zero_exc: got %b want 0", e); end
  endtask

  task automatic test_round();
    logic [15:0] r; logic e; int lat;
    logic [15:0] want;
`ifdef FPADD_ROUND_EN
    want = 16'h3C01;
`else
    want = 16'h3C00;
`endif
    run_op(16'h3C00, 16'h1200, 1'b0, r, e, lat);
    n_cmp++; if (r !== want) begin n_err++; $display("FAIL round_grs: got %h want %h", r, want); end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic e; int lat;
    run_op(16'h7BFF, 16'h7BFF, 1'b0, r, e, lat);
    n_cmp++; if (r !== 16'h7C00) begin n_err++; $display("FAIL overflow: got %h want 7c00", r); end
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL overflow_exc: got %b want 1", e); end
  endtask

  task automatic test_exception();
    logic [15:0] r; logic e; int lat;
    run_op(16'h7C00, 16'h3C00, 1'b0, r, e, lat);
    n_cmp++; if (r !== 16'h0000) begin n_err++; $display("FAIL inf_in: got %h want 0000", r); end
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL inf_in_exc: got %b want 1", e); end
    run_op(16'h0001, 16'h3C00, 1'b0, r, e, lat);
    n_cmp++; if (r !== 16'h3C00) begin n_err++; $display("FAIL subnormal_flush: got %h want 3c00", r); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL subnormal_exc: got %b want 0", e); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bv [8];
    logic [15:0] ev [8];
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    int extra = 0;
    // 1.0 + {1..8} = {2..9}
    bv = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    ev = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
    while (out_idx < 8 && cyc < 200) begin
      @(posedge clk); #1;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      sub = 1'b0;
      if (in_idx < 8) begin
        in_valid = 1'b1; a_operand = 16'h3C00; b_operand = bv[in_idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        n_err++; $display("FAIL bp_in_ready: got %b want %b (cycle %0d)", in_ready, ~(out_valid & ~out_ready), cyc);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (result !== ev[out_idx]) begin
          n_err++; $display("FAIL bp_result[%0d]: got %h want %h", out_idx, result, ev[out_idx]);
        end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      cyc++;
    end
    n_cmp++; if (out_idx !== 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", out_idx); end
    n_cmp++; if (in_idx !== 8) begin n_err++; $display("FAIL bp_accepted: got %0d want 8", in_idx); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      #1;
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL bp_duplicates: got %0d want 0", extra); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    @(posedge clk); #1;
    out_ready = 1'b1; sub = 1'b0; in_valid = 1'b1;
    a_operand = 16'h3C00; b_operand = 16'h3C00;
    @(posedge clk); #1; b_operand = 16'h4000;
    @(posedge clk); #1; b_operand = 16'h4200;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL rst_mid_result: got %h want 0000", result); end
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_round();
    test_overflow();
    test_exception();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
